updown_btn_ctrl: RTL and testbench
==================================

Name: updown_btn_ctrl

Overview:
- Upstream control stage for the 3-bit synchronous up/down counter.
- Turns two raw, bouncy pushbuttons into clean counter controls:
  - the direction level `up_down`;
  - a counter-clear pulse `cnt_clr`, which drives the counter's reset input;
  - a one-cycle direction-change event `dir_evt`.
- Each button goes through a 2-flop synchronizer and a per-button debounce state machine.

Parameters:
- DB_CYCLES, 4, consecutive stable synchronized samples needed to accept a press or a release (legal range 1 to 255).
- CLR_PULSE, 1, width of `cnt_clr` in clock cycles (legal range 1 to 15).
- UP_AT_RESET, 1, value of `up_down` after reset (1 = count up).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_dir_raw  input  1  raw direction button; asynchronous, may bounce.
- btn_clr_raw  input  1  raw clear button; asynchronous, may bounce.
- dir_lock  input  1  synchronous; while high, accepted direction presses are discarded.
- up_down  output  1  registered direction to the counter: 1 = up, 0 = down.
- cnt_clr  output  1  registered clear pulse to the counter's reset.
- dir_evt  output  1  registered one-cycle strobe in the cycle `up_down` has just toggled.

Behaviour:
- Reset (asynchronous, active-high), all state forced to:
  - synchronizer flops = 0;
  - both FSMs = IDLE;
  - debounce counters = 0, clear-pulse counter = 0;
  - `up_down` = UP_AT_RESET, `cnt_clr` = 0, `dir_evt` = 0.
- Synchronizer: two flops per button; `s` denotes the second-stage output.
- Debounce FSM, one instance per button, with counter `dbc` of width clog2(DB_CYCLES+1):
  - IDLE: if s=1, go to ARMING with dbc=1; if DB_CYCLES=1, go straight to PRESSED and raise the accept strobe.
  - ARMING:
    - s=0: return to IDLE, dbc=0.
    - s=1 and dbc=DB_CYCLES-1: go to PRESSED and raise the accept strobe on that edge.
    - otherwise: dbc+1.
  - PRESSED: if s=0, go to RELEASING with dbc=1 (DB_CYCLES=1 goes straight to IDLE). Holding the button never re-triggers.
  - RELEASING:
    - s=1: return to PRESSED.
    - s=0 and dbc=DB_CYCLES-1: go to IDLE.
    - otherwise: dbc+1.
- Press latency: raw button first sampled high at edge 0 and held stable → accept occurs at edge DB_CYCLES+1 (edge 5 by default).
- Bounce rejection: any high burst of s shorter than DB_CYCLES produces no accept.
- Direction accept:
  - If dir_lock=0 on the accept edge: `up_down` inverts and `dir_evt`=1 for exactly that one following cycle.
  - If dir_lock=1: no toggle, no `dir_evt`, and the press is consumed. The FSM still goes to PRESSED, so a later unlock does not replay it.
- Clear accept:
  - On the accept edge, `cnt_clr` goes to 1 and the pulse counter loads CLR_PULSE-1.
  - `cnt_clr` stays high for exactly CLR_PULSE cycles, then returns to 0.
  - A new clear accept while the pulse is active reloads the counter, extending the pulse; there is no gap.
- Simultaneous events: a direction accept and a clear accept on the same edge both take effect. `cnt_clr` does not change `up_down`.
- `dir_evt` and `cnt_clr` never glitch; both are flop outputs.
- Reset mid-operation (during ARMING, RELEASING or an active clear pulse): outputs return to reset values immediately. A button still held after reset deasserts must pass through the full ARMING sequence, so it produces exactly one accept.

Test Plan:
- Reset with UP_AT_RESET=1, buttons low, 10 ns clock → `up_down`=1, `cnt_clr`=0, `dir_evt`=0; all hold for 20 cycles.
- btn_dir_raw held high from edge 0, DB_CYCLES=4 → `up_down` goes 1→0 at edge 5, `dir_evt`=1 for the cycle after edge 5 only. Holding 30 more cycles gives no further toggle. Release, then press again → `up_down` returns to 1.
- btn_dir_raw bouncing pattern 1,1,0,1,1,1,0 then steady 1 → no toggle during the bounce; exactly one toggle 5 edges after the final steady rise.
- dir_lock=1 during a full press → `up_down` and `dir_evt` unchanged. Set dir_lock=0 while the button is still held → still no toggle; the next fresh press toggles.
- CLR_PULSE=3; clear press accepted at edge N → `cnt_clr`=1 for edges N..N+2, 0 at N+3. A second clear accept at N+2 extends the pulse to end at N+5. A concurrent direction press on the same edge also toggles `up_down`.
- Assert reset while the clear FSM is in ARMING (dbc=2) and `cnt_clr` is active → outputs return to reset values immediately. Button still held after reset deasserts → exactly one `cnt_clr` pulse, 5 edges later.

Source files
------------

// File: rtl/updown_btn_ctrl.sv
// rtl/updown_btn_ctrl.sv - button front end producing direction, clear pulse and direction event for the up/down counter
//
// Purpose:
//   Takes two raw, bouncy pushbuttons. Each one passes through a 2-flop
//   synchronizer and then its own debounce FSM. An accepted press becomes a
//   clean control for the downstream 3-bit up/down counter.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   btn_dir_raw  in   raw direction button (asynchronous, bouncy)
//   btn_clr_raw  in   raw clear button (asynchronous, bouncy)
//   dir_lock     in   synchronous; discards accepted direction presses while high
//   up_down      out  registered direction, 1 = up
//   cnt_clr      out  registered clear pulse, CLR_PULSE cycles wide
//   dir_evt      out  registered one-cycle strobe when up_down has just toggled
module updown_btn_ctrl #(
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned CLR_PULSE   = 1,
  parameter bit          UP_AT_RESET = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_dir_raw,
  input  logic btn_clr_raw,
  input  logic dir_lock,
  output logic up_down,
  output logic cnt_clr,
  output logic dir_evt
);

  localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
  localparam int unsigned PCW = $clog2(CLR_PULSE + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [PCW-1:0] PC_LOAD = PCW'(CLR_PULSE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } db_state_e;

  // Bit 0 = direction button, bit 1 = clear button.
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {btn_clr_raw, btn_dir_raw};
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_db
    db_state_e      state_q;
    logic [DBW-1:0] dbc_q;
    logic           s;

    assign s = sync2_q[g];

    // Accept is decoded from the current state so the output stage reacts on
    // the same edge that moves the FSM into PRESSED.
    assign accept[g] = s && (((state_q == ARMING) && (dbc_q == DB_LAST)) ||
                             ((state_q == IDLE) && (DB_CYCLES == 1)));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        dbc_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (s) begin
              if (DB_CYCLES == 1) begin
                state_q <= PRESSED;
                dbc_q   <= '0;
              end else begin
                state_q <= ARMING;
                dbc_q   <= DBW'(1);
              end
            end
          end
          ARMING: begin
            if (!s) begin
              state_q <= IDLE;
              dbc_q   <= '0;
            end else if (dbc_q == DB_LAST) begin
              state_q <= PRESSED;
              dbc_q   <= '0;
            end else begin
              dbc_q <= dbc_q + DBW'(1);
            end
          end
          PRESSED: begin
            // Holding stays here forever; only a debounced release leaves.
            if (!s) begin
              if (DB_CYCLES == 1) begin
                state_q <= IDLE;
                dbc_q   <= '0;
              end else begin
                state_q <= RELEASING;
                dbc_q   <= DBW'(1);
              end
            end
          end
          RELEASING: begin
            if (s) begin
              state_q <= PRESSED;
              dbc_q   <= '0;
            end else if (dbc_q == DB_LAST) begin
              state_q <= IDLE;
              dbc_q   <= '0;
            end else begin
              dbc_q <= dbc_q + DBW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            dbc_q   <= '0;
          end
        endcase
      end
    end
  end

  logic           up_down_q, up_down_d;
  logic           dir_evt_q, dir_evt_d;
  logic           cnt_clr_q, cnt_clr_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;

  always_comb begin
    up_down_d = up_down_q;
    dir_evt_d = 1'b0;
    cnt_clr_d = 1'b0;
    pcnt_d    = '0;

    // A locked press is simply dropped; the FSM has already consumed it.
    if (accept[0] && !dir_lock) begin
      up_down_d = ~up_down_q;
      dir_evt_d = 1'b1;
    end

    // A fresh accept reloads the remaining count, so overlapping presses
    // stretch the pulse without a low gap.
    if (accept[1]) begin
      cnt_clr_d = 1'b1;
      pcnt_d    = PC_LOAD;
    end else if (pcnt_q != '0) begin
      cnt_clr_d = 1'b1;
      pcnt_d    = pcnt_q - PCW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_down_q <= UP_AT_RESET;
      dir_evt_q <= 1'b0;
      cnt_clr_q <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      up_down_q <= up_down_d;
      dir_evt_q <= dir_evt_d;
      cnt_clr_q <= cnt_clr_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign up_down = up_down_q;
  assign dir_evt = dir_evt_q;
  assign cnt_clr = cnt_clr_q;

endmodule

// File: tb/tb_updown_btn_ctrl.sv
// tb/tb_updown_btn_ctrl.sv - directed scoreboard bench for updown_btn_ctrl
module tb_updown_btn_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_a = 1'b0, c_a = 1'b0, l_a = 1'b0;
  logic d_b = 1'b0, c_b = 1'b0, l_b = 1'b0;
  logic ud_a, clr_a, evt_a;
  logic ud_b, clr_b, evt_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Entry: {dut select (0 = A, 1 = B), up_down, cnt_clr, dir_evt}
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  updown_btn_ctrl #(.DB_CYCLES(4), .CLR_PULSE(3), .UP_AT_RESET(1'b1)) dut_a (
    .clk(clk), .reset(rst), .btn_dir_raw(d_a), .btn_clr_raw(c_a), .dir_lock(l_a),
    .up_down(ud_a), .cnt_clr(clr_a), .dir_evt(evt_a)
  );

  updown_btn_ctrl #(.DB_CYCLES(1), .CLR_PULSE(3), .UP_AT_RESET(1'b0)) dut_b (
    .clk(clk), .reset(rst), .btn_dir_raw(d_b), .btn_clr_raw(c_b), .dir_lock(l_b),
    .up_down(ud_b), .cnt_clr(clr_b), .dir_evt(evt_b)
  );

  task automatic check(input string tag);
    logic [3:0] e;
    logic [2:0] obs;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e   = exp_q.pop_front();
    obs = e[3] ? {ud_b, clr_b, evt_b} : {ud_a, clr_a, evt_a};
    assert (obs === e[2:0]) else begin
      n_fail++;
      $error("FAIL %s: observed {up_down,cnt_clr,dir_evt}=%b expected %b", tag, obs, e[2:0]);
    end
  endtask

  task automatic expect_now(input logic sel, input logic [2:0] exp, input string tag);
    exp_q.push_back({sel, exp});
    check(tag);
  endtask

  task automatic step(input logic sel, input logic d, input logic c, input logic l,
                      input logic [2:0] exp, input string tag);
    if (sel) begin
      d_b = d; c_b = c; l_b = l;
    end else begin
      d_a = d; c_a = c; l_a = l;
    end
    exp_q.push_back({sel, exp});
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic hold(input logic sel, input logic d, input logic c, input logic l,
                      input int n, input logic [2:0] exp, input string tag);
    for (int i = 0; i < n; i++) step(sel, d, c, l, exp, tag);
  endtask

  initial begin
    logic [6:0] pat;

    // Reset values and idle hold
    repeat (3) @(posedge clk);
    #1;
    expect_now(1'b0, 3'b100, "rst_a");
    expect_now(1'b1, 3'b000, "rst_b");
    rst = 1'b0;
    hold(1'b0, 1'b0, 1'b0, 1'b0, 20, 3'b100, "idle_a");
    expect_now(1'b1, 3'b000, "idle_b");

    // Held direction press: toggle at edge 5, no retrigger, second press toggles back
    hold(1'b0, 1'b1, 1'b0, 1'b0, 5, 3'b100, "dir_wait");
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, "dir_accept");
    hold(1'b0, 1'b1, 1'b0, 1'b0, 31, 3'b000, "dir_held");
    hold(1'b0, 1'b0, 1'b0, 1'b0, 8, 3'b000, "dir_release");
    hold(1'b0, 1'b1, 1'b0, 1'b0, 5, 3'b000, "dir2_wait");
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'b101, "dir2_accept");
    hold(1'b0, 1'b1, 1'b0, 1'b0, 5, 3'b100, "dir2_held");
    hold(1'b0, 1'b0, 1'b0, 1'b0, 8, 3'b100, "dir2_release");

    // Bounce 1,1,0,1,1,1,0 then steady high
    pat = 7'b1101110;
    for (int i = 6; i >= 0; i--) step(1'b0, pat[i], 1'b0, 1'b0, 3'b100, "bounce");
    hold(1'b0, 1'b1, 1'b0, 1'b0, 5, 3'b100, "bounce_steady");
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, "bounce_accept");
    hold(1'b0, 1'b1, 1'b0, 1'b0, 3, 3'b000, "bounce_held");
    hold(1'b0, 1'b0, 1'b0, 1'b0, 8, 3'b000, "bounce_release");

    // Locked press is consumed, unlock while held does not replay it
    hold(1'b0, 1'b1, 1'b0, 1'b1, 10, 3'b000, "lock_press");
    hold(1'b0, 1'b1, 1'b0, 1'b0, 10, 3'b000, "unlock_held");
    hold(1'b0, 1'b0, 1'b0, 1'b0, 8, 3'b000, "lock_release");
    hold(1'b0, 1'b1, 1'b0, 1'b0, 5, 3'b000, "fresh_wait");
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'b101, "fresh_accept");
    hold(1'b0, 1'b1, 1'b0, 1'b0, 3, 3'b100, "fresh_held");
    hold(1'b0, 1'b0, 1'b0, 1'b0, 8, 3'b100, "fresh_release");

    // Concurrent clear + direction press, 3-cycle clear pulse
    hold(1'b0, 1'b1, 1'b1, 1'b0, 5, 3'b100, "both_wait");
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'b011, "both_accept");
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, "clr_n1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, "clr_n2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, "clr_n3_low");
    hold(1'b0, 1'b1, 1'b1, 1'b0, 3, 3'b000, "both_held");
    hold(1'b0, 1'b0, 1'b0, 1'b0, 8, 3'b000, "both_release");

    // DB_CYCLES=1 instance: clear accepts at N and N+2 extend pulse to N+5;
    // direction accept lands on the N+2 edge
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, "ext_e0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, "ext_e1");
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, "ext_n");
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, "ext_n1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b111, "ext_n2_both");
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b110, "ext_n3");
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b110, "ext_n4");
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b100, "ext_n5_low");
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b100, "ext_after");

    // Reset during ARMING (A) and during an active clear pulse (B)
    hold(1'b0, 1'b0, 1'b0, 1'b0, 2, 3'b000, "mid_idle");
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, "mid_e0");
    c_b = 1'b1;
    hold(1'b0, 1'b0, 1'b1, 1'b0, 3, 3'b000, "mid_arming");
    expect_now(1'b1, 3'b110, "mid_b_pulse");
    rst = 1'b1;
    c_b = 1'b0;
    #1;
    expect_now(1'b0, 3'b100, "async_rst_a");
    expect_now(1'b1, 3'b000, "async_rst_b");
    @(posedge clk);
    #1;
    expect_now(1'b0, 3'b100, "rst_hold_a");
    rst = 1'b0;
    hold(1'b0, 1'b0, 1'b1, 1'b0, 5, 3'b100, "rearm_wait");
    hold(1'b0, 1'b0, 1'b1, 1'b0, 3, 3'b110, "rearm_pulse");
    hold(1'b0, 1'b0, 1'b1, 1'b0, 10, 3'b100, "rearm_once");
    hold(1'b0, 1'b0, 1'b0, 1'b0, 4, 3'b100, "rearm_release");
    expect_now(1'b1, 3'b000, "b_quiet");

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
